// File: rtl/hicore_commit_ctrl.sv
// hicore_commit_ctrl
//   In-order commit controller downstream of the reorder buffer. Pulls the
//   ROB head through the commit handshake, applies regfile / CSR writes in the
//   retire cycle, raises traps, mret and fence.i side effects, and generates
//   the pipeline flush plus fetch redirect. Commits are held off while a
//   flush or an instruction-cache invalidate sequence is in progress.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   commit_valid / commit_ready     ROB head commit handshake
//   commit_rd_* / commit_csr_*      head destination register / CSR info
//   commit_fence_i_op, commit_mret_op, commit_next_pc, commit_info
//                                   head op flags, next PC, writeback info
//                                   (info[0] exception, info[1] redirect,
//                                   info[7:4] exception cause)
//   flush                           pipeline + ROB flush pulse
//   redirect_valid / redirect_pc    fetch redirect
//   rf_wen / rf_widx / rf_wdata     integer regfile write port
//   csr_wen / csr_widx / csr_wdata  CSR write port
//   trap_valid / trap_cause / trap_epc  trap entry to CSR unit
//   mret_done                       mret retired
//   csr_mtvec, csr_mepc             trap and return targets
//   icache_inv_req / icache_inv_ack fence.i invalidate handshake
//   instret                         retired instruction count
//
// Configuration macro:
//   HICORE_COMMIT_INSTRET_EN  defined: 64-bit wrapping retire counter on
//                             instret; undefined: instret tied to zero.
module hicore_commit_ctrl #(
    parameter int XLEN          = 32,
    parameter int INFO_W        = 8,
    parameter int RST_PC_UNUSED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              commit_valid,
    input  logic              commit_ready,
    input  logic              commit_rd_need,
    input  logic [4:0]        commit_rd_idx,
    input  logic [XLEN-1:0]   commit_rd_data,
    input  logic              commit_csr_need,
    input  logic [11:0]       commit_csr_idx,
    input  logic [XLEN-1:0]   commit_csr_data,
    input  logic              commit_fence_i_op,
    input  logic              commit_mret_op,
    input  logic [XLEN-1:0]   commit_next_pc,
    input  logic [INFO_W-1:0] commit_info,
    output logic              flush,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              rf_wen,
    output logic [4:0]        rf_widx,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              csr_wen,
    output logic [11:0]       csr_widx,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              trap_valid,
    output logic [3:0]        trap_cause,
    output logic [XLEN-1:0]   trap_epc,
    output logic              mret_done,
    input  logic [XLEN-1:0]   csr_mtvec,
    input  logic [XLEN-1:0]   csr_mepc,
    output logic              icache_inv_req,
    input  logic              icache_inv_ack,
    output logic [63:0]       instret
);

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_FENCEI_REQ,
        S_FENCEI_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] target, target_nxt;
    logic            fencei_first, fencei_first_nxt;

    logic retire;
    logic exc;
    logic fence_win;
    logic mret_win;
    logic redir_win;
    logic unused_info;

    assign unused_info = ^commit_info[3:2];

    assign commit_valid = (state == S_RUN);
    assign retire       = commit_valid & commit_ready;

    // Priority: exception > fence.i > mret > mispredict redirect.
    assign exc       = commit_info[0];
    assign fence_win = commit_fence_i_op & ~exc;
    assign mret_win  = commit_mret_op & ~exc & ~commit_fence_i_op;
    assign redir_win = commit_info[1] & ~exc & ~commit_fence_i_op & ~commit_mret_op;

    always_comb begin
        state_nxt        = state;
        target_nxt       = target;
        fencei_first_nxt = 1'b0;
        case (state)
            S_RUN: begin
                if (retire) begin
                    if (exc) begin
                        target_nxt = csr_mtvec;
                        state_nxt  = S_FLUSH;
                    end else if (fence_win) begin
                        target_nxt       = commit_next_pc;
                        fencei_first_nxt = 1'b1;
                        state_nxt        = S_FENCEI_REQ;
                    end else if (mret_win) begin
                        target_nxt = csr_mepc;
                        state_nxt  = S_FLUSH;
                    end else if (redir_win) begin
                        target_nxt = commit_next_pc;
                        state_nxt  = S_FLUSH;
                    end
                end
            end
            S_FLUSH:       state_nxt = S_RUN;
            S_FENCEI_REQ:  if (icache_inv_ack) state_nxt = S_FENCEI_DONE;
            S_FENCEI_DONE: state_nxt = S_RUN;
            default:       state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_RUN;
            target       <= XLEN'(RST_PC_UNUSED);
            fencei_first <= 1'b0;
        end else begin
            state        <= state_nxt;
            target       <= target_nxt;
            fencei_first <= fencei_first_nxt;
        end
    end

    assign rf_wen    = retire & ~exc & commit_rd_need & (commit_rd_idx != '0);
    assign rf_widx   = commit_rd_idx;
    assign rf_wdata  = commit_rd_data;
    assign csr_wen   = retire & ~exc & commit_csr_need;
    assign csr_widx  = commit_csr_idx;
    assign csr_wdata = commit_csr_data;

    assign trap_valid = retire & exc;
    assign trap_cause = commit_info[7:4];
    assign trap_epc   = commit_next_pc - XLEN'(4);
    assign mret_done  = retire & mret_win;

    // fence.i flushes only on the first invalidate-request cycle.
    assign flush          = (state == S_FLUSH) | ((state == S_FENCEI_REQ) & fencei_first);
    assign redirect_valid = (state == S_FLUSH) | (state == S_FENCEI_DONE);
    assign redirect_pc    = target;
    assign icache_inv_req = (state == S_FENCEI_REQ);

`ifdef HICORE_COMMIT_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_hicore_commit_ctrl.sv
module tb_hicore_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit_valid, commit_ready;
    logic        commit_rd_need;
    logic [4:0]  commit_rd_idx;
    logic [31:0] commit_rd_data;
    logic        commit_csr_need;
    logic [11:0] commit_csr_idx;
    logic [31:0] commit_csr_data;
    logic        commit_fence_i_op, commit_mret_op;
    logic [31:0] commit_next_pc;
    logic [7:0]  commit_info;
    logic        flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        rf_wen;
    logic [4:0]  rf_widx;
    logic [31:0] rf_wdata;
    logic        csr_wen;
    logic [11:0] csr_widx;
    logic [31:0] csr_wdata;
    logic        trap_valid;
    logic [3:0]  trap_cause;
    logic [31:0] trap_epc;
    logic        mret_done;
    logic [31:0] csr_mtvec, csr_mepc;
    logic        icache_inv_req, icache_inv_ack;
    logic [63:0] instret;

    always #5 clk = ~clk;

    hicore_commit_ctrl #(.XLEN(32), .INFO_W(8), .RST_PC_UNUSED(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_rd_need(commit_rd_need), .commit_rd_idx(commit_rd_idx),
        .commit_rd_data(commit_rd_data),
        .commit_csr_need(commit_csr_need), .commit_csr_idx(commit_csr_idx),
        .commit_csr_data(commit_csr_data),
        .commit_fence_i_op(commit_fence_i_op), .commit_mret_op(commit_mret_op),
        .commit_next_pc(commit_next_pc), .commit_info(commit_info),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rf_wen(rf_wen), .rf_widx(rf_widx), .rf_wdata(rf_wdata),
        .csr_wen(csr_wen), .csr_widx(csr_widx), .csr_wdata(csr_wdata),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc),
        .mret_done(mret_done), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .icache_inv_req(icache_inv_req), .icache_inv_ack(icache_inv_ack),
        .instret(instret)
    );

    typedef struct {
        logic        cv;
        logic        rf_wen;
        logic [4:0]  rf_widx;
        logic [31:0] rf_wdata;
        logic        csr_wen;
        logic [11:0] csr_widx;
        logic [31:0] csr_wdata;
        logic        trap;
        logic [3:0]  cause;
        logic [31:0] epc;
        logic        mret;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic        inv;
        logic [63:0] instret;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] n_ret  = '0;
    exp_t        e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_instret();
`ifdef HICORE_COMMIT_INSTRET_EN
        return n_ret;
`else
        return 64'd0;
`endif
    endfunction

    function automatic exp_t base();
        exp_t r;
        r = '{cv: 1'b1, rf_wen: 1'b0, rf_widx: '0, rf_wdata: '0, csr_wen: 1'b0,
              csr_widx: '0, csr_wdata: '0, trap: 1'b0, cause: '0, epc: '0,
              mret: 1'b0, flush: 1'b0, redir: 1'b0, rpc: '0, inv: 1'b0,
              instret: exp_instret()};
        return r;
    endfunction

    // Monitor: whenever the DUT shows commit activity, pop the next expected record.
    always @(negedge clk) begin
        logic act;
        exp_t x;
        if (rst_n === 1'b1) begin
            act = (commit_valid & commit_ready) | flush | redirect_valid | icache_inv_req
                | trap_valid | mret_done | rf_wen | csr_wen;
            if (act) begin
                check("queue_has_entry", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    x = q.pop_front();
                    check("commit_valid", 64'(commit_valid), 64'(x.cv));
                    check("rf_wen", 64'(rf_wen), 64'(x.rf_wen));
                    if (x.rf_wen) begin
                        check("rf_widx", 64'(rf_widx), 64'(x.rf_widx));
                        check("rf_wdata", 64'(rf_wdata), 64'(x.rf_wdata));
                    end
                    check("csr_wen", 64'(csr_wen), 64'(x.csr_wen));
                    if (x.csr_wen) begin
                        check("csr_widx", 64'(csr_widx), 64'(x.csr_widx));
                        check("csr_wdata", 64'(csr_wdata), 64'(x.csr_wdata));
                    end
                    check("trap_valid", 64'(trap_valid), 64'(x.trap));
                    if (x.trap) begin
                        check("trap_cause", 64'(trap_cause), 64'(x.cause));
                        check("trap_epc", 64'(trap_epc), 64'(x.epc));
                    end
                    check("mret_done", 64'(mret_done), 64'(x.mret));
                    check("flush", 64'(flush), 64'(x.flush));
                    check("redirect_valid", 64'(redirect_valid), 64'(x.redir));
                    if (x.redir) check("redirect_pc", 64'(redirect_pc), 64'(x.rpc));
                    check("icache_inv_req", 64'(icache_inv_req), 64'(x.inv));
                    check("instret", instret, x.instret);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        commit_ready      = 1'b0;
        commit_rd_need    = 1'b0;
        commit_rd_idx     = '0;
        commit_rd_data    = '0;
        commit_csr_need   = 1'b0;
        commit_csr_idx    = '0;
        commit_csr_data   = '0;
        commit_fence_i_op = 1'b0;
        commit_mret_op    = 1'b0;
        commit_next_pc    = '0;
        commit_info       = '0;
        icache_inv_ack    = 1'b0;
    endtask

    task automatic push_ret(input exp_t r);
        q.push_back(r);
        n_ret = n_ret + 64'd1;
    endtask

    task automatic push(input exp_t r);
        q.push_back(r);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_flush"}, 64'(flush), 64'd0);
        check({tag, "_redirect_valid"}, 64'(redirect_valid), 64'd0);
        check({tag, "_redirect_pc"}, 64'(redirect_pc), 64'd0);
        check({tag, "_inv_req"}, 64'(icache_inv_req), 64'd0);
        check({tag, "_trap_valid"}, 64'(trap_valid), 64'd0);
        check({tag, "_mret_done"}, 64'(mret_done), 64'd0);
        check({tag, "_instret"}, instret, 64'd0);
        check({tag, "_commit_valid"}, 64'(commit_valid), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        csr_mtvec = '0;
        csr_mepc  = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        reset_checks("rst");
        tick();

        // ALU op to x5
        clear_in(); commit_ready = 1; commit_rd_need = 1; commit_rd_idx = 5; commit_rd_data = 32'h1234;
        e = base(); e.rf_wen = 1; e.rf_widx = 5; e.rf_wdata = 32'h1234; push_ret(e); tick();
        // rd = x0: retire, no regfile write
        clear_in(); commit_ready = 1; commit_rd_need = 1; commit_rd_idx = 0; commit_rd_data = 32'hffff;
        e = base(); push_ret(e); tick();
        // CSR write
        clear_in(); commit_ready = 1; commit_csr_need = 1; commit_csr_idx = 12'h305; commit_csr_data = 32'hdeadbeef;
        e = base(); e.csr_wen = 1; e.csr_widx = 12'h305; e.csr_wdata = 32'hdeadbeef; push_ret(e); tick();
        // ROB not ready: no side effects at all
        clear_in(); commit_rd_need = 1; commit_rd_idx = 7; commit_csr_need = 1; tick();

        // Mispredict
        clear_in(); commit_ready = 1; commit_info = 8'h02; commit_next_pc = 32'h80000100;
        commit_rd_need = 1; commit_rd_idx = 3; commit_rd_data = 32'h55;
        e = base(); e.rf_wen = 1; e.rf_widx = 3; e.rf_wdata = 32'h55; push_ret(e); tick();
        clear_in(); commit_ready = 1; commit_rd_need = 1; commit_rd_idx = 4; commit_rd_data = 32'h1;
        e = base(); e.cv = 0; e.flush = 1; e.redir = 1; e.rpc = 32'h80000100; push(e); tick();
        clear_in(); commit_ready = 1; commit_rd_need = 1; commit_rd_idx = 4; commit_rd_data = 32'h77;
        e = base(); e.rf_wen = 1; e.rf_widx = 4; e.rf_wdata = 32'h77; push_ret(e); tick();

        // Exception, cause 2
        clear_in(); commit_ready = 1; commit_info = 8'h21; commit_next_pc = 32'h204;
        commit_rd_need = 1; commit_rd_idx = 9; commit_rd_data = 32'h1; commit_csr_need = 1; commit_csr_idx = 12'h1;
        csr_mtvec = 32'h100;
        e = base(); e.trap = 1; e.cause = 4'h2; e.epc = 32'h200; push_ret(e); tick();
        clear_in(); csr_mtvec = 32'h999;
        e = base(); e.cv = 0; e.flush = 1; e.redir = 1; e.rpc = 32'h100; push(e); tick();

        // Exception with every flag set and epc wrap-around
        clear_in(); commit_ready = 1; commit_info = 8'hF3; commit_next_pc = 32'h0;
        commit_fence_i_op = 1; commit_mret_op = 1; csr_mtvec = 32'h180; csr_mepc = 32'h300;
        e = base(); e.trap = 1; e.cause = 4'hF; e.epc = 32'hFFFFFFFC; push_ret(e); tick();
        clear_in();
        e = base(); e.cv = 0; e.flush = 1; e.redir = 1; e.rpc = 32'h180; push(e); tick();

        // mret beats redirect
        clear_in(); commit_ready = 1; commit_mret_op = 1; commit_info = 8'h02; commit_next_pc = 32'h999;
        e = base(); e.mret = 1; push_ret(e); tick();
        clear_in();
        e = base(); e.cv = 0; e.flush = 1; e.redir = 1; e.rpc = 32'h300; push(e); tick();

        // fence.i beats mret; ack delayed by 5 cycles; head stays ready throughout
        clear_in(); commit_ready = 1; commit_fence_i_op = 1; commit_mret_op = 1; commit_next_pc = 32'h40;
        e = base(); push_ret(e); tick();
        clear_in(); commit_ready = 1; commit_rd_need = 1; commit_rd_idx = 2; commit_rd_data = 32'h22;
        e = base(); e.cv = 0; e.flush = 1; e.inv = 1; push(e); tick();
        for (int i = 0; i < 4; i++) begin
            e = base(); e.cv = 0; e.inv = 1; push(e); tick();
        end
        icache_inv_ack = 1;
        e = base(); e.cv = 0; e.inv = 1; push(e); tick();
        icache_inv_ack = 0;
        e = base(); e.cv = 0; e.redir = 1; e.rpc = 32'h40; push(e); tick();
        e = base(); e.rf_wen = 1; e.rf_widx = 2; e.rf_wdata = 32'h22; push_ret(e); tick();

        // fence.i with ack already high: minimum latency
        clear_in(); commit_ready = 1; commit_fence_i_op = 1; commit_next_pc = 32'h80;
        e = base(); push_ret(e); tick();
        clear_in(); commit_ready = 1; icache_inv_ack = 1;
        e = base(); e.cv = 0; e.flush = 1; e.inv = 1; push(e); tick();
        icache_inv_ack = 0;
        e = base(); e.cv = 0; e.redir = 1; e.rpc = 32'h80; push(e); tick();
        e = base(); push_ret(e); tick();

        // Reset while in FENCEI_REQ
        clear_in(); commit_ready = 1; commit_fence_i_op = 1; commit_next_pc = 32'h40;
        e = base(); push_ret(e); tick();
        clear_in();
        e = base(); e.cv = 0; e.flush = 1; e.inv = 1; push(e);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        n_ret = '0;
        #1;
        reset_checks("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        reset_checks("postrst");
        @(posedge clk);
        #1;

        // 10 back-to-back retires from a fresh counter
        for (int i = 0; i < 10; i++) begin
            clear_in(); commit_ready = 1; commit_rd_need = 1;
            commit_rd_idx = 5'(i + 1); commit_rd_data = 32'(i * 3);
            e = base(); e.rf_wen = 1; e.rf_widx = 5'(i + 1); e.rf_wdata = 32'(i * 3);
            push_ret(e); tick();
        end
        clear_in();
        tick();
`ifdef HICORE_COMMIT_INSTRET_EN
        check("instret_after_10", instret, 64'd10);
`else
        check("instret_tied_zero", instret, 64'd0);
`endif
        tick();
        check("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
